// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative multiply/divide unit.
// Holds op codes, FSM state encoding and the default operand width.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_MULT  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: unsigned shift-add multiply / restoring divide step.
// Ports: i_load latches magnitudes, i_step runs one iteration,
// i_is_div selects divide; o_acc = product high / remainder,
// o_q = product low / quotient.
module muldiv_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sum;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;

   always_comb begin
      w_add = r_q[0] ? {1'b0, r_b} : '0;
      w_sum = {1'b0, r_acc} + w_add;
      // partial remainder shifted left with next dividend bit
      w_ge  = {r_acc, r_q[WIDTH-1]} >= {1'b0, r_b};
      w_sub = {r_acc[WIDTH-2:0], r_q[WIDTH-1]} - r_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_q   <= '0;
         r_b   <= '0;
      end else if (i_load) begin
         r_acc <= '0;
         r_q   <= i_a;
         r_b   <= i_b;
      end else if (i_step) begin
         if (i_is_div) begin
            if (w_ge) begin
               r_acc <= w_sub;
               r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
               r_acc <= {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
               r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
         end
      end
   end

   assign o_acc = r_acc;
   assign o_q   = r_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// Ports: start/op/a/b launch, hi_we/lo_we/wdata for MTHI/MTLO,
// busy/done/div_by_zero status, hi/lo results.
// Optional MULDIV_ABORT_EN adds an abort input for pipeline flush.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e             r_state;
   state_e             w_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_div0;
   logic [WIDTH-1:0]   r_a_orig;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;
   logic               r_dz;

   op_e                w_op;
   logic               w_is_div;
   logic               w_signed;
   logic               w_div0;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic               w_load;
   logic               w_step;
   logic               w_fix;
   logic               w_abort;
   logic [WIDTH-1:0]   w_acc;
   logic [WIDTH-1:0]   w_q;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_hi_res;
   logic [WIDTH-1:0]   w_lo_res;

`ifdef MULDIV_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_op     = op_e'(op);
   assign w_is_div = (w_op == OP_DIVU) || (w_op == OP_DIV);
   assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
   assign w_div0   = w_is_div && (b == '0);
   assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
   assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt  = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      w_fix  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load = 1'b1;
               w_nxt  = ST_CALC;
            end
         end
         ST_CALC: begin
            w_step = 1'b1;
            if (r_cnt == CNT_W'(WIDTH-1)) w_nxt = ST_FIX;
         end
         ST_FIX: begin
            w_fix = 1'b1;
            w_nxt = ST_IDLE;
         end
         default: w_nxt = ST_IDLE;
      endcase
      if (w_abort && (r_state != ST_IDLE)) begin
         w_step = 1'b0;
         w_fix  = 1'b0;
         w_nxt  = ST_IDLE;
      end
   end

   // divide by zero runs a single dummy step so done lands at k+2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_cnt <= '0;
      else if (w_load) r_cnt <= w_div0 ? CNT_W'(WIDTH-1) : '0;
      else if (w_step) r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_a_orig <= '0;
      end else if (w_load) begin
         r_is_div <= w_is_div;
         r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
         r_neg_r  <= w_signed && a[WIDTH-1];
         r_div0   <= w_div0;
         r_a_orig <= a;
      end
   end

   muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_is_div (r_is_div),
      .i_a      (w_a_mag),
      .i_b      (w_b_mag),
      .o_acc    (w_acc),
      .o_q      (w_q)
   );

   always_comb begin
      w_prod = {w_acc, w_q};
      if (r_neg_q) w_prod = -w_prod;
      w_hi_res = w_prod[2*WIDTH-1:WIDTH];
      w_lo_res = w_prod[WIDTH-1:0];
      if (r_div0) begin
         w_hi_res = r_a_orig;
         w_lo_res = '1;
      end else if (r_is_div) begin
         w_hi_res = r_neg_r ? -w_acc : w_acc;
         w_lo_res = r_neg_q ? -w_q : w_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
         r_dz   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         if (w_fix) begin
            r_hi   <= w_hi_res;
            r_lo   <= w_lo_res;
            r_done <= 1'b1;
            r_dz   <= r_div0;
         end else if (r_state == ST_IDLE) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
         end
      end
   end

   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign div_by_zero = r_dz;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the EX stage, beside the ALU result select.
- Consumes the same A/B operands as the ALU select.
- Produces the 64-bit result into architectural HI/LO registers. Quotient/remainder and full products come from here instead of the single-cycle paths.
- Busy output lets hazard logic stall dependent MFHI/MFLO and new mult/div issue.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO updated by an operation
- div_by_zero  out  1  pulses with done when a divide had b==0
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- One clock domain; reset is asynchronous, active-low (rst_n). Clock is clk.
- Reset values: busy=0, done=0, div_by_zero=0, hi=0, lo=0, FSM=IDLE, counter=0.
- FSM states:
  - IDLE: on start at edge k, latch op; latch |a|,|b| (signed ops) or a,b (unsigned); record result signs; go to CALC. Exception: a divide with b==0 goes to FIX directly.
  - CALC: one shift-add (mult) or one restoring-subtract step (div) per cycle, WIDTH cycles, counter counts 0..WIDTH-1. Leaves for FIX after the last step.
  - FIX: apply sign correction; write hi/lo; assert done; return to IDLE.
- Latency:
  - busy=1 from edge k through the FIX cycle.
  - done=1 and hi/lo valid after edge k+WIDTH+1; busy=0 in that same cycle.
  - The next start is accepted in that cycle.
- Divide by zero: FIX reached at edge k+1 (done visible after edge k+2); hi=a (original), lo=all-ones, div_by_zero=1 with done.
- Signed rules:
  - Product negated when sign(a)!=sign(b).
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no flag.
- Operands: a/b are sampled only at start; later changes are ignored.
- start while busy is ignored (no queueing); issue logic must stall.
- hi_we/lo_we:
  - Take effect at the next edge when not busy.
  - Ignored while busy.
  - If asserted together with start in IDLE, the write lands and the operation's FIX later overwrites it.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro MULDIV_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - Abort high in CALC/FIX → next state IDLE, busy=0 next cycle, done not pulsed, hi/lo unchanged.
  - Used for exception flush.
  - Abort in IDLE has no effect; abort has priority over start.
- Without it: no abort port; an operation always runs to completion.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings (OP_MULTU, OP_DIVU, OP_MULT, OP_DIV)
  - FSM state encoding (ST_IDLE, ST_CALC, ST_FIX)
  - WIDTH default constant
- One natural sub-module, muldiv_datapath: accumulator/shift registers and add/subtract step. Top holds the FSM, counter, sign bookkeeping and HI/LO.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → done at cycle k+33, hi=0xFFFFFFFE, lo=0x00000001, busy high for exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100 b=0 → done at k+2, div_by_zero=1, hi=100, lo=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2, div_by_zero=0.
- start pulsed again mid-CALC with different operands → ignored; first result unchanged; lo_we with wdata=0x1234 while busy → lo unaffected.
- rst_n dropped at cycle k+10 of a DIV → busy, done, hi, lo go to 0 asynchronously; a fresh MULTU 6*7 afterwards gives lo=42, hi=0.
- With MULDIV_ABORT_EN: abort at k+5 of MULT following prior result hi=0, lo=42 → busy=0 next cycle, no done, hi/lo still 0/42.
